// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : switch_debounce_pkg                                        |
// | Brief   : Shared FSM state encoding and default timing constants for |
// |           the switch synchroniser/debouncer.                         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package switch_debounce_pkg;

  // Per-channel debounce states; the encoding is fixed so that bit 1
  // reads as the currently accepted level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  // 20 ms settle time at 25 MHz.
  localparam int unsigned c_debounce_cycles_def = 500000;
  // 0.5 s hold before the first auto-repeat, then 100 ms between repeats.
  localparam int unsigned c_repeat_delay_def    = 12500000;
  localparam int unsigned c_repeat_period_def   = 2500000;

  // Largest of three values, used to size the shared channel counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_debounce_channel                                    |
// | Brief   : Single-bit two-flop synchroniser, debounce FSM and         |
// |           saturating counter producing a clean level plus one-cycle  |
// |           rise/fall strobes.                                         |
// | Config  : SWITCH_REPEAT_EN adds auto-repeat rise strobes while held. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module switch_debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def
`ifdef SWITCH_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = c_repeat_delay_def,
  parameter int unsigned REPEAT_PERIOD   = c_repeat_period_def
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

`ifdef SWITCH_REPEAT_EN
  localparam int unsigned c_cnt_max = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
`else
  localparam int unsigned c_cnt_max = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned c_cnt_w = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
`ifdef SWITCH_REPEAT_EN
  localparam logic [c_cnt_w-1:0] c_dly_last = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_per_last = c_cnt_w'(REPEAT_PERIOD - 1);
`endif

  logic               r_s1;
  logic               r_s2;
  db_state_t          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_rise;
  logic               r_fall;
  logic [c_cnt_w-1:0] w_cnt_inc;
`ifdef SWITCH_REPEAT_EN
  // Set once the first repeat has fired; selects delay vs period compare.
  logic               r_rep;
`endif

  // Saturating increment so the counter can never wrap.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + c_cnt_one);

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive opposing samples; any agreeing sample aborts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`ifdef SWITCH_REPEAT_EN
      r_rep   <= 1'b0;
`endif
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (r_s2) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= STABLE_HI;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= WAIT_HI;
              r_cnt   <= c_cnt_one;
            end
          end
        end
        WAIT_HI: begin
          if (!r_s2) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == c_db_last) begin
            r_state <= STABLE_HI;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!r_s2) begin
`ifdef SWITCH_REPEAT_EN
            r_rep <= 1'b0;
`endif
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= STABLE_LO;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= WAIT_LO;
              r_cnt   <= c_cnt_one;
            end
          end else begin
`ifdef SWITCH_REPEAT_EN
            // Hold timer: first strobe after the delay, then every period.
            if (r_cnt == (r_rep ? c_per_last : c_dly_last)) begin
              r_rise <= 1'b1;
              r_rep  <= 1'b1;
              r_cnt  <= '0;
            end else begin
              r_cnt  <= w_cnt_inc;
            end
`endif
          end
        end
        WAIT_LO: begin
          if (r_s2) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == c_db_last) begin
            r_state <= STABLE_LO;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sw_level = r_level;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_debounce                                            |
// | Brief   : N independent switch channels, each synchronised and      |
// |           debounced, giving clean levels and rise/fall strobes for   |
// |           switch_control.                                            |
// | Config  : SWITCH_REPEAT_EN enables auto-repeat rise strobes.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned N               = 3,
  parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def
`ifdef SWITCH_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = c_repeat_delay_def,
  parameter int unsigned REPEAT_PERIOD   = c_repeat_period_def
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_level,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall
);

  // One fully independent debounce channel per switch bit.
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    switch_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SWITCH_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sw_raw   (sw_raw[gi]),
      .sw_level (sw_level[gi]),
      .sw_rise  (sw_rise[gi]),
      .sw_fall  (sw_fall[gi])
    );
  end

endmodule
`default_nettype wire
